// File: rtl/seq_divider_pkg.sv
// Shared definitions for seq_divider: FSM state encoding and default operand widths.
package seq_divider_pkg;

    localparam int DW_DEFAULT = 6;
    localparam int VW_DEFAULT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : seq_divider_pkg

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Optional macro SEQ_DIVIDER_DZ_DETECT_EN short-circuits a zero divisor straight to DONE with dz=1.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int VW = VW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dz
);

    localparam int CW = $clog2(DW + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [VW-1:0] prem_q, prem_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [DW-1:0] dq_q, dq_d;
    logic [VW-1:0] dvs_q, dvs_d;
    logic [DW-1:0] quo_q, quo_d;
    logic [VW-1:0] rem_q, rem_d;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
    logic          dz_q, dz_d;
`endif

    logic [VW:0]   shifted;
    logic [VW+1:0] diff;
    logic          q_bit;
    logic [VW:0]   prem_next;

    // A kept partial remainder is always below the divisor, so VW bits store it;
    // the shifted trial value needs VW+1 bits and the subtraction one more for the sign.
    always_comb begin
        shifted   = {prem_q, dq_q[DW-1]};
        diff      = {1'b0, shifted} - {2'b00, dvs_q};
        q_bit     = ~diff[VW+1];
        prem_next = q_bit ? diff[VW:0] : shifted;
    end

    always_comb begin
        // NOTE: every target takes its held value first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        dq_d    = dq_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
        dz_d    = dz_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dq_d    = dividend;
                    dvs_d   = divisor;
                    cnt_d   = '0;
                    prem_d  = '0;
                    state_d = CALC;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = '0;
                        dz_d    = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                dq_d   = {dq_q[DW-2:0], q_bit};
                prem_d = prem_next[VW-1:0];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = DONE;
                    quo_d   = {dq_q[DW-2:0], q_bit};
                    rem_d   = prem_next[VW-1:0];
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
                    dz_d    = 1'b0;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            dq_q    <= dq_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
            dz_q    <= dz_d;
`endif
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
    assign dz        = dz_q;
`else
    assign dz        = 1'b0;
`endif

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, exhaustive sweep and random operands
// compared against an arithmetic reference model.
module tb_seq_divider;
    import seq_divider_pkg::*;

    localparam int DW = DW_DEFAULT;
    localparam int VW = VW_DEFAULT;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dz;

    int checks = 0;
    int errors = 0;

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dz        (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: integer division; latency in edges after the capture edge.
    function automatic void model(input int a, input int b,
                                  output int q, output int r, output int z, output int lat);
        if (b != 0) begin
            q = a / b;  r = a % b;  z = 0;  lat = DW;
        end else begin
            q = (1 << DW) - 1;
`ifdef SEQ_DIVIDER_DZ_DETECT_EN
            r = 0;  z = 1;  lat = 0;
`else
            r = a % (1 << VW);  z = 0;  lat = DW;
`endif
        end
    endfunction

    // Runs one division; inj_k >= 0 drives a spurious start (divisor=1) sampled on edge inj_k+1.
    task automatic run_div(input int a, input int b, input int inj_k, input string tag);
        int q, r, z, lat, seen_lat, pulses;
        model(a, b, q, r, z, lat);
        @(negedge clk);
        start = 1'b1;  dividend = DW'(a);  divisor = VW'(b);
        @(posedge clk);
        #1 start = 1'b0;
        seen_lat = -1;
        pulses   = 0;
        for (int k = 0; k <= DW + 3; k++) begin
            @(negedge clk);
            if (k == 0 && lat > 0) check({tag, " busy_after_start"}, 32'(busy), 32'd1);
            if (done) begin
                pulses++;
                if (seen_lat < 0) seen_lat = k;
                check({tag, " quotient"},  32'(quotient),  32'(q));
                check({tag, " remainder"}, 32'(remainder), 32'(r));
                check({tag, " dz"},        32'(dz),        32'(z));
                check({tag, " busy_in_done"}, 32'(busy),   32'd1);
            end
            if (k == inj_k) begin
                start = 1'b1;  dividend = DW'($urandom);  divisor = VW'(1);
            end else if (k == inj_k + 1) begin
                start = 1'b0;
            end
        end
        check({tag, " done_pulses"},  32'(pulses),    32'd1);
        check({tag, " latency"},      32'(seen_lat),  32'(lat));
        check({tag, " idle_after"},   32'(busy),      32'd0);
        check({tag, " quotient_hold"},32'(quotient),  32'(q));
    endtask

    initial begin
        int a, b;
        rst_n = 1'b0;  start = 1'b0;  dividend = '0;  divisor = '0;
        repeat (2) @(negedge clk);
        check("reset busy",      32'(busy),      32'd0);
        check("reset done",      32'(done),      32'd0);
        check("reset quotient",  32'(quotient),  32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dz",        32'(dz),        32'd0);
        rst_n = 1'b1;

        run_div(30, 5, -1, "30/5");
        run_div(45, 7, -1, "45/7");
        run_div(5, 7, -1, "5/7");
        run_div(63, 7, 3, "63/7 start_in_calc");
        run_div(42, 0, -1, "42/0");
        run_div(45, 7, DW, "45/7 start_in_done");

        // Reset in the middle of CALC: abort without done, then a normal division.
        @(negedge clk);
        start = 1'b1;  dividend = DW'(30);  divisor = VW'(5);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy",      32'(busy),      32'd0);
        check("abort done",      32'(done),      32'd0);
        check("abort quotient",  32'(quotient),  32'd0);
        check("abort remainder", 32'(remainder), 32'd0);
        check("abort dz",        32'(dz),        32'd0);
        begin
            int pulses = 0;
            for (int k = 0; k < DW + 2; k++) begin
                @(negedge clk);
                if (k == 2) rst_n = 1'b1;
                if (done) pulses++;
            end
            check("abort no_done", 32'(pulses), 32'd0);
        end
        run_div(30, 5, -1, "30/5 after_reset");

        for (int i = 0; i < (1 << DW); i++)
            for (int j = 1; j < (1 << VW); j++)
                run_div(i, j, -1, "sweep");

        for (int n = 0; n < 40; n++) begin
            a = int'($urandom_range((1 << DW) - 1, 0));
            b = int'($urandom_range((1 << VW) - 1, 0));
            run_div(a, b, (n % 4 == 0) ? int'($urandom_range(DW - 1, 1)) : -1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_seq_divider

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter DW, default 6, meaning dividend and quotient width in bits.
REQ-002 The block SHALL have parameter VW, default 3, meaning divisor and remainder width in bits; VW <= DW.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to begin a division.
REQ-006 The block SHALL have port dividend, input, DW, unsigned dividend, sampled with start.
REQ-007 The block SHALL have port divisor, input, VW, unsigned divisor, sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high while a division is in progress.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse marking results valid.
REQ-010 The block SHALL have port quotient, output, DW, unsigned quotient.
REQ-011 The block SHALL have port remainder, output, VW, unsigned remainder.
REQ-012 The block SHALL have port dz, output, 1, divide-by-zero flag, valid with done.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC, DONE; restoring division, one quotient bit per clock, MSB first.
REQ-014 In IDLE, start=1 at a rising edge SHALL capture dividend/divisor, clear the iteration counter and partial remainder, and move to CALC.
REQ-015 In CALC, each edge SHALL shift the next dividend bit into a VW+1-bit partial remainder, subtract divisor when the result is >= 0, and set the quotient bit to 1 if subtracted, else 0.
REQ-016 After exactly DW CALC edges, the FSM SHALL move to DONE; done SHALL be high for exactly one cycle in DONE; DONE SHALL return to IDLE on the next edge.
REQ-017 Latency: done SHALL be visible on the DW-th rising edge after the edge that samples start (6 edges at defaults).
REQ-018 busy SHALL be high in CALC and DONE and low in IDLE.
REQ-019 start while busy=1 SHALL be ignored; no capture and no effect on the running division.
REQ-020 start asserted in the cycle done is high SHALL be ignored; it is accepted from IDLE only.
REQ-021 quotient/remainder SHALL satisfy quotient*divisor + remainder = dividend, remainder < divisor, for divisor != 0.
REQ-022 quotient, remainder and dz SHALL hold their values from done until the next accepted start; they are undefined-but-stable during CALC.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, dz=0, quotient=0, remainder=0, and the counter and partial remainder to 0.
REQ-024 A reset during CALC or DONE SHALL abort the division without producing done; the next start after release SHALL operate normally.

Configuration
REQ-025 With macro SEQ_DIVIDER_DZ_DETECT_EN defined, a captured divisor of 0 SHALL bypass CALC, enter DONE on the capture edge, and give quotient=all ones, remainder=0, dz=1 with done.
REQ-026 Without SEQ_DIVIDER_DZ_DETECT_EN, dz SHALL be tied 0 and divisor 0 SHALL run the normal DW-cycle path, giving quotient=all ones and remainder=dividend[VW-1:0].

Structure
REQ-027 The state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default DW/VW values SHALL live in a shared package/header, seq_divider_pkg, reused by the bench.
REQ-028 The block SHALL be a single module with no sub-module; the counter width SHALL be clog2(DW+1).

Verification
REQ-029 The bench SHALL check dividend=30, divisor=5 -> done 6 edges after start, quotient=6, remainder=0, dz=0.
REQ-030 The bench SHALL check dividend=45, divisor=7 -> quotient=6, remainder=3; and dividend=5, divisor=7 -> quotient=0, remainder=5.
REQ-031 The bench SHALL check dividend=63, divisor=7 -> quotient=9, remainder=0, and start pulsed at edge 3 of CALC with divisor=1 -> ignored, result unchanged.
REQ-032 The bench SHALL check divisor=0, dividend=42 -> with macro: done on the next cycle, quotient=63, remainder=0, dz=1; without macro: done after 6 edges, quotient=63, remainder=2, dz=0.
REQ-033 The bench SHALL check rst_n pulled low at CALC edge 3 -> busy=0, done never pulses, outputs 0; then 30/5 after release -> quotient=6, remainder=0.
REQ-034 The bench SHALL check an exhaustive sweep of all dividends 0..63 and divisors 1..7 -> every result satisfies REQ-021, with done exactly once per start.
